// File: rtl/demux_12_stream_pkg.sv
// Shared constants for the 1:2 stream demux and its mux-side sender.
// Also holds the helper that sizes the FIFO pointers.
package demux_12_stream_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;

    // Keeps pointers at least one bit wide so DEPTH=1 still elaborates.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Show-ahead channel FIFO for any DEPTH, not only powers of two.
// A push while full and a pop while empty are both ignored.
module demux_chan_fifo
    import demux_12_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             full
);

    localparam int PW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    // Once drained, the output keeps showing the word that was popped last.
    assign head_data = valid ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/demux_12_stream.sv
// Splits one select-tagged stream into channels A (sel=0) and B (sel=1).
// Each channel has its own FIFO, so a stalled consumer only blocks its own words.
module demux_12_stream
    import demux_12_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [CW-1:0]    a_count,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CW-1:0]    b_count
);

    logic a_full;
    logic b_full;
    logic push_a;
    logic push_b;

    // A full target refuses the word even if it pops this cycle: no pass-through.
    assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
    assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b   = in_valid && in_ready && (in_sel == SEL_B);

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .head_data (a_data),
        .valid     (a_valid),
        .count     (a_count),
        .full      (a_full)
    );

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .head_data (b_data),
        .valid     (b_valid),
        .count     (b_count),
        .full      (b_full)
    );

endmodule

// File: tb/tb_demux_12_stream.sv
// Directed bench: a DEPTH=2 instance for steering, backpressure and reset,
// and a DEPTH=3 instance for pointer wrap-around on channel B.
module tb_demux_12_stream;

    logic clk;
    logic rst_n;

    logic       in_valid, in_ready, in_sel;
    logic [7:0] in_data;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [7:0] a_data, b_data;
    logic [1:0] a_count, b_count;

    logic       in_valid3, in_ready3, in_sel3;
    logic [7:0] in_data3;
    logic       a_valid3, a_ready3, b_valid3, b_ready3;
    logic [7:0] a_data3, b_data3;
    logic [1:0] a_count3, b_count3;

    int n_checks = 0;
    int n_fail   = 0;

    demux_12_stream #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    demux_12_stream #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid3),
        .in_ready (in_ready3),
        .in_sel   (in_sel3),
        .in_data  (in_data3),
        .a_valid  (a_valid3),
        .a_ready  (a_ready3),
        .a_data   (a_data3),
        .a_count  (a_count3),
        .b_valid  (b_valid3),
        .b_ready  (b_ready3),
        .b_data   (b_data3),
        .b_count  (b_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcvd;
        int cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0; in_sel  = 1'b0; in_data  = 8'h00; a_ready  = 1'b0; b_ready  = 1'b0;
        in_valid3 = 1'b0; in_sel3 = 1'b0; in_data3 = 8'h00; a_ready3 = 1'b0; b_ready3 = 1'b0;
        #2;
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_b_valid", b_valid, 0);
        check_eq("rst_a_count", a_count, 0);
        check_eq("rst_b_count", b_count, 0);
        check_eq("rst_a_data",  a_data, 8'h00);
        check_eq("rst_b_data",  b_data, 8'h00);
        check_eq("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Steering: 11 -> A, 22 -> B, 33 -> A with both consumers ready.
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
        settle();
        check_eq("steer_in_ready", in_ready, 1);
        tick();
        check_eq("steer_a_valid1", a_valid, 1);
        check_eq("steer_a_data1",  a_data, 8'h11);
        check_eq("steer_b_valid1", b_valid, 0);
        in_sel = 1'b1; in_data = 8'h22;
        tick();
        check_eq("steer_a_valid2", a_valid, 0);
        check_eq("steer_b_valid2", b_valid, 1);
        check_eq("steer_b_data2",  b_data, 8'h22);
        in_sel = 1'b0; in_data = 8'h33;
        tick();
        check_eq("steer_a_valid3", a_valid, 1);
        check_eq("steer_a_data3",  a_data, 8'h33);
        check_eq("steer_b_valid3", b_valid, 0);
        in_valid = 1'b0;
        tick();
        check_eq("steer_a_drain", a_valid, 0);

        // Backpressure isolation: fill A, then B must still accept.
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h41;
        tick();
        in_data = 8'h42;
        tick();
        in_data = 8'h43;
        settle();
        check_eq("bp_a_count_full", a_count, 2);
        check_eq("bp_in_ready_a",   in_ready, 0);
        check_eq("bp_a_head",       a_data, 8'h41);
        in_sel = 1'b1; in_data = 8'h51;
        settle();
        check_eq("bp_in_ready_b", in_ready, 1);
        tick();
        check_eq("bp_b_count", b_count, 1);
        check_eq("bp_b_data",  b_data, 8'h51);
        check_eq("bp_a_count_hold", a_count, 2);

        // Full A with a pop this cycle: push still refused.
        in_sel = 1'b0; in_data = 8'h43; a_ready = 1'b1;
        settle();
        check_eq("fullpop_in_ready0", in_ready, 0);
        tick();
        check_eq("fullpop_a_count1", a_count, 1);
        check_eq("fullpop_a_head",   a_data, 8'h42);
        check_eq("fullpop_in_ready1", in_ready, 1);
        tick();
        check_eq("pushpop_a_count", a_count, 1);
        check_eq("pushpop_a_head",  a_data, 8'h43);
        in_valid = 1'b0;
        tick();
        check_eq("pushpop_a_drain", a_count, 0);

        // Concurrent pops on both channels with a push to A on the same edge.
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h61;
        tick();
        check_eq("cp_a_count_pre", a_count, 1);
        check_eq("cp_b_count_pre", b_count, 1);
        a_ready = 1'b1; b_ready = 1'b1; in_data = 8'h62;
        tick();
        check_eq("cp_a_count", a_count, 1);
        check_eq("cp_a_data",  a_data, 8'h62);
        check_eq("cp_b_count", b_count, 0);
        check_eq("cp_b_valid", b_valid, 0);
        in_valid = 1'b0;
        tick();
        check_eq("cp_a_drain", a_valid, 0);

        // Asynchronous reset mid-cycle with two words held in A.
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h71;
        tick();
        in_data = 8'h72;
        tick();
        in_valid = 1'b0;
        settle();
        check_eq("ar_a_count_pre", a_count, 2);
        check_eq("ar_in_ready_pre", in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ar_a_valid",  a_valid, 0);
        check_eq("ar_a_count",  a_count, 0);
        check_eq("ar_in_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("ar_a_valid_post", a_valid, 0);
        check_eq("ar_a_count_post", a_count, 0);

        // Wrap-around on the DEPTH=3 instance: 10 words to B, b_ready toggling.
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        in_sel3 = 1'b1;
        while (rcvd < 10 && cyc < 200) begin
            b_ready3  = (cyc % 2 == 0);
            in_valid3 = (sent < 10);
            in_data3  = 8'(sent);
            settle();
            if (b_valid3 && b_ready3) begin
                check_eq("wrap_b_data", b_data3, rcvd);
                rcvd++;
            end
            check_eq("wrap_b_count_max", (b_count3 <= 2'd3), 1);
            if (in_valid3 && in_ready3) sent++;
            tick();
            cyc++;
        end
        in_valid3 = 1'b0;
        b_ready3  = 1'b0;
        check_eq("wrap_words_rcvd", rcvd, 10);
        check_eq("wrap_a_untouched", a_count3, 0);
        settle();
        check_eq("wrap_b_empty", b_valid3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
